dbus_arbiter: RTL and testbench



---
 rtl/dbus_arbiter.sv | 85 ++++++++
 tb/tb_dbus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: LSU/PTW data-bus arbiter that registers the winning request, holds it
// on the bus until mem_ack_i, routes the response back, and swallows flushed LSU acks.
module dbus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsu_req_i,
  input  logic                lsu_st_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic                lsu_flush_i,
  output logic                lsu_ack_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  input  logic                ptw_req_i,
  input  logic                ptw_st_i,
  input  logic [ADDR_W-1:0]   ptw_addr_i,
  input  logic [DATA_W-1:0]   ptw_wdata_i,
  input  logic [DATA_W/8-1:0] ptw_be_i,
  output logic                ptw_ack_o,
  output logic [DATA_W-1:0]   ptw_rdata_o,
  output logic                mem_req_o,
  output logic                mem_st_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                arb_busy_o
);
  typedef enum logic [1:0] {IDLE, BUSY_LSU, BUSY_PTW} state_t;
  state_t              r_state, w_next;
  logic                r_last_ptw, r_drop, r_st;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_be;
  logic                w_lsu_v, w_grant, w_pick_ptw;
  always_comb begin
    w_lsu_v    = lsu_req_i & ~lsu_flush_i;
    w_grant    = (r_state == IDLE) & (w_lsu_v | ptw_req_i);
    // PTW wins when alone, or on a tie when LSU had the previous grant
    w_pick_ptw = ptw_req_i & (~w_lsu_v | ~r_last_ptw);
    w_next     = r_state;
    if (r_state == IDLE)
      w_next = w_grant ? (w_pick_ptw ? BUSY_PTW : BUSY_LSU) : IDLE;
    else if (mem_ack_i)
      w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ptw <= 1'b0;
      r_drop     <= 1'b0;
      r_st       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else begin
      r_drop <= (w_next == IDLE) ? 1'b0
              : r_drop | (lsu_flush_i & (r_state == BUSY_LSU | w_next == BUSY_LSU));
      if (w_grant) begin
        r_last_ptw <= w_pick_ptw;
        r_st       <= w_pick_ptw ? ptw_st_i    : lsu_st_i;
        r_addr     <= w_pick_ptw ? ptw_addr_i  : lsu_addr_i;
        r_wdata    <= w_pick_ptw ? ptw_wdata_i : lsu_wdata_i;
        r_be       <= w_pick_ptw ? ptw_be_i    : lsu_be_i;
      end
    end
  end
  assign arb_busy_o  = (r_state != IDLE);
  assign mem_req_o   = arb_busy_o;
  assign mem_st_o    = r_st;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  // a flush in the ack cycle itself must also suppress the ack
  assign lsu_ack_o   = mem_ack_i & (r_state == BUSY_LSU) & ~r_drop & ~lsu_flush_i;
  assign ptw_ack_o   = mem_ack_i & (r_state == BUSY_PTW);
  assign lsu_rdata_o = lsu_ack_o ? mem_rdata_i : '0;
  assign ptw_rdata_o = ptw_ack_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level model of the arbiter.
module tb_dbus_arbiter;
  logic        clk, rst_n;
  logic        lsu_req_i, lsu_st_i, lsu_flush_i, lsu_ack_o;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [3:0]  lsu_be_i;
  logic        ptw_req_i, ptw_st_i, ptw_ack_o;
  logic [31:0] ptw_addr_i, ptw_wdata_i, ptw_rdata_o;
  logic [3:0]  ptw_be_i;
  logic        mem_req_o, mem_st_o, mem_ack_i, arb_busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  int checks = 0;
  int failures = 0;

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_st_i(lsu_st_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i), .lsu_flush_i(lsu_flush_i),
    .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o),
    .ptw_req_i(ptw_req_i), .ptw_st_i(ptw_st_i), .ptw_addr_i(ptw_addr_i),
    .ptw_wdata_i(ptw_wdata_i), .ptw_be_i(ptw_be_i),
    .ptw_ack_o(ptw_ack_o), .ptw_rdata_o(ptw_rdata_o),
    .mem_req_o(mem_req_o), .mem_st_o(mem_st_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .arb_busy_o(arb_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic lreq, lflush, preq, mack;
    logic [31:0] rdata;
    logic ereq;
    logic [31:0] eaddr;
    logic elack, epack;
  } vec_t;
  vec_t tbl[12];

  // transaction-level model: who owns the bus, who was granted last, killed flag, captured request
  int          m_own, m_last;
  bit          m_kill;
  logic        m_st;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ereq, input logic est, input logic [31:0] eaddr,
                         input logic [31:0] ewdata, input logic [3:0] ebe, input logic elack, input logic epack);
    chk({tag, ".mem_req"}, 32'(mem_req_o), 32'(ereq));
    chk({tag, ".busy"}, 32'(arb_busy_o), 32'(ereq));
    chk({tag, ".mem_st"}, 32'(mem_st_o), 32'(est));
    chk({tag, ".mem_addr"}, mem_addr_o, eaddr);
    chk({tag, ".mem_wdata"}, mem_wdata_o, ewdata);
    chk({tag, ".mem_be"}, 32'(mem_be_o), 32'(ebe));
    chk({tag, ".lsu_ack"}, 32'(lsu_ack_o), 32'(elack));
    chk({tag, ".ptw_ack"}, 32'(ptw_ack_o), 32'(epack));
    chk({tag, ".lsu_rdata"}, lsu_rdata_o, elack ? mem_rdata_i : 32'h0);
    chk({tag, ".ptw_rdata"}, ptw_rdata_o, epack ? mem_rdata_i : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lsu_req_i = 0; lsu_st_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_be_i = 0; lsu_flush_i = 0;
    ptw_req_i = 0; ptw_st_i = 0; ptw_addr_i = 0; ptw_wdata_i = 0; ptw_be_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 1; m_kill = 0;
    m_st = 0; m_addr = 0; m_wdata = 0; m_be = 0;
  endtask

  task automatic model_step();
    bit lv, pv;
    int win;
    lv = lsu_req_i && !lsu_flush_i;
    pv = ptw_req_i;
    if (m_own == 0) begin
      if (lv || pv) begin
        win = (lv && pv) ? (m_last == 2 ? 1 : 2) : (lv ? 1 : 2);
        m_own = win; m_last = win; m_kill = 0;
        m_st    = (win == 1) ? lsu_st_i    : ptw_st_i;
        m_addr  = (win == 1) ? lsu_addr_i  : ptw_addr_i;
        m_wdata = (win == 1) ? lsu_wdata_i : ptw_wdata_i;
        m_be    = (win == 1) ? lsu_be_i    : ptw_be_i;
      end
    end else if (mem_ack_i) begin
      m_own = 0; m_kill = 0;
    end else if (m_own == 1 && lsu_flush_i) m_kill = 1;
  endtask

  initial begin
    bit e_lack, e_pack, fl;
    rst_n = 0;
    clear_inputs();
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h2000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA1,       1'b1, 32'h2000, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h2000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hB2,       1'b1, 32'h1000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hE5,       1'b0, 32'h1000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hC3,       1'b1, 32'h2000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h2000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h1000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1000, 1'b0, 1'b0};
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    lsu_addr_i = 32'h1000;
    ptw_addr_i = 32'h2000;
    for (int i = 0; i < 12; i++) begin
      lsu_req_i = tbl[i].lreq; lsu_flush_i = tbl[i].lflush; ptw_req_i = tbl[i].preq;
      mem_ack_i = tbl[i].mack; mem_rdata_i = tbl[i].rdata;
      #1;
      chk_all($sformatf("tbl%0d", i), tbl[i].ereq, 0, tbl[i].eaddr, 0, 0, tbl[i].elack, tbl[i].epack);
      tick();
    end
    clear_inputs();
    lsu_req_i = 1; lsu_addr_i = 32'h10;
    #1;
    chk_all("hold.idle", 0, 0, 32'h1000, 0, 0, 0, 0);
    tick();
    lsu_addr_i = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_all("hold.busy", 1, 0, 32'h10, 0, 0, 0, 0);
      tick();
    end
    mem_ack_i = 1; mem_rdata_i = 32'h77;
    #1;
    chk_all("hold.ack", 1, 0, 32'h10, 0, 0, 1, 0);
    tick();
    clear_inputs();
    lsu_req_i = 1; lsu_st_i = 1; lsu_addr_i = 32'h40; lsu_wdata_i = 32'h55; lsu_be_i = 4'hF;
    tick();
    lsu_req_i = 0; lsu_flush_i = 1;
    #1;
    chk_all("flush.pulse", 1, 1, 32'h40, 32'h55, 4'hF, 0, 0);
    tick();
    lsu_flush_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h99;
    #1;
    chk_all("flush.ack", 1, 1, 32'h40, 32'h55, 4'hF, 0, 0);
    tick();
    mem_ack_i = 0;
    #1;
    chk_all("flush.idle", 0, 1, 32'h40, 32'h55, 4'hF, 0, 0);
    lsu_req_i = 1; lsu_st_i = 0; lsu_addr_i = 32'h80; lsu_wdata_i = 0; lsu_be_i = 0;
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h1234;
    #1;
    chk_all("flush.next", 1, 0, 32'h80, 0, 0, 1, 0);
    tick();
    lsu_addr_i = 32'h90; mem_ack_i = 0;
    #1;
    chk_all("newreq.idle", 0, 0, 32'h80, 0, 0, 0, 0);
    tick();
    mem_ack_i = 1; lsu_flush_i = 1; mem_rdata_i = 32'h5;
    #1;
    chk_all("flush.same", 1, 0, 32'h90, 0, 0, 0, 0);
    tick();
    clear_inputs();
    #1;
    chk_all("flush.same.idle", 0, 0, 32'h90, 0, 0, 0, 0);
    ptw_req_i = 1; ptw_addr_i = 32'h300;
    tick();
    #1;
    chk_all("rst.busy", 1, 0, 32'h300, 0, 0, 0, 0);
    rst_n = 0; mem_ack_i = 1; ptw_req_i = 0;
    #1;
    chk_all("rst.low", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
    #1;
    chk_all("rst.lateack", 0, 0, 0, 0, 0, 0, 0);
    tick();
    mem_ack_i = 0;
    lsu_req_i = 1; lsu_addr_i = 32'h1000; ptw_req_i = 1; ptw_addr_i = 32'h2000;
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h42;
    #1;
    chk_all("rst.tie", 1, 0, 32'h2000, 0, 0, 0, 1);
    tick();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!lsu_req_i && $urandom_range(2) == 0) begin
        lsu_req_i = 1; lsu_st_i = 1'($urandom_range(1));
        lsu_addr_i = $urandom; lsu_wdata_i = $urandom; lsu_be_i = 4'($urandom);
      end
      if (!ptw_req_i && $urandom_range(2) == 0) begin
        ptw_req_i = 1; ptw_st_i = 1'($urandom_range(1));
        ptw_addr_i = $urandom; ptw_wdata_i = $urandom; ptw_be_i = 4'($urandom);
      end
      lsu_flush_i = ($urandom_range(15) == 0);
      mem_ack_i = ($urandom_range(2) == 0);
      mem_rdata_i = $urandom;
      #1;
      e_lack = mem_ack_i && m_own == 1 && !m_kill && !lsu_flush_i;
      e_pack = mem_ack_i && m_own == 2;
      chk_all("rand", m_own != 0, m_st, m_addr, m_wdata, m_be, e_lack, e_pack);
      fl = lsu_flush_i;
      model_step();
      tick();
      if (e_lack || fl) lsu_req_i = 0;
      if (e_pack) ptw_req_i = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
